// File: rtl/node_mac_seq.sv
`default_nettype none
// ============================================================================
// Module      : node_mac_seq
// Description : Sequential fixed-point neuron. One multiply-accumulate per
//               accepted activation, then bias, shift, saturate and ReLU.
// Revision    : 1.0 - initial release
// ============================================================================
module node_mac_seq #(
    parameter  int N_IN  = 30,
    parameter  int DW    = 16,
    parameter  int FRAC  = 8,
    localparam int AW    = $clog2(N_IN + 1),
    localparam int ACC_W = 2 * DW + $clog2(N_IN + 1) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    input  logic                 w_we,
    input  logic [AW-1:0]        w_addr,
    input  logic signed [DW-1:0] w_data,
    input  logic                 relu_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data,
    output logic                 out_sat
);

    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;

    localparam logic [AW-1:0] C_LAST      = AW'(N_IN - 1);
    localparam logic [AW-1:0] C_BIAS_ADDR = AW'(N_IN);

    localparam logic signed [ACC_W-1:0] C_SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] C_SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_FINAL = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic signed [DW-1:0]    r_weight [N_IN];
    logic signed [DW-1:0]    r_bias;
    logic [AW-1:0]           r_cnt;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_out_valid;
    logic signed [DW-1:0]    r_out_data;
    logic                    r_out_sat;

    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_last;
    logic signed [2*DW-1:0]  w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_bias_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_shift;
    logic signed [DW-1:0]    w_res;
    logic                    w_sat;

    assign w_accept   = in_valid & w_in_ready;
    assign w_last     = (r_cnt == C_LAST);
    assign w_prod     = in_data * r_weight[r_cnt[IW-1:0]];
    assign w_prod_ext = {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};
    assign w_bias_ext = {{(ACC_W-DW){r_bias[DW-1]}}, r_bias};
    assign w_sum      = r_acc + (w_bias_ext <<< FRAC);
    assign w_shift    = w_sum >>> FRAC;

    // Clamp the full-precision result; ReLU applies after saturation.
    always_comb begin
        w_sat = 1'b0;
        w_res = w_shift[DW-1:0];
        if (w_shift > C_SAT_MAX) begin
            w_res = {1'b0, {(DW-1){1'b1}}};
            w_sat = 1'b1;
        end else if (w_shift < C_SAT_MIN) begin
            w_res = {1'b1, {(DW-1){1'b0}}};
            w_sat = 1'b1;
        end
        if (relu_en && w_res[DW-1]) begin
            w_res = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            ST_ACCUM: begin
                w_in_ready = 1'b1;
                if (w_accept && w_last) begin
                    w_state_nxt = ST_FINAL;
                end
            end
            ST_FINAL: begin
                w_state_nxt = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            default: begin
                w_state_nxt = ST_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N_IN; i++) begin
                r_weight[i] <= '0;
            end
            r_bias      <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            // Coefficient writes land regardless of state; reads this cycle see the old value.
            if (w_we) begin
                if (w_addr == C_BIAS_ADDR) begin
                    r_bias <= w_data;
                end else if (w_addr < C_BIAS_ADDR) begin
                    r_weight[w_addr[IW-1:0]] <= w_data;
                end
            end
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= r_acc + w_prod_ext;
                        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                    end
                end
                ST_FINAL: begin
                    r_out_data  <= w_res;
                    r_out_sat   <= w_sat;
                    r_out_valid <= 1'b1;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;

endmodule
`default_nettype wire

// File: tb/tb_node_mac_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_node_mac_seq
// Description : Scoreboard bench for node_mac_seq (N_IN=4, DW=16, FRAC=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_node_mac_seq;

    localparam int N_IN = 4;
    localparam int DW   = 16;
    localparam int FRAC = 8;
    localparam int AW   = $clog2(N_IN + 1);

    typedef logic [DW-1:0] frame_t [N_IN];
    typedef struct {
        logic [DW-1:0] d;
        logic          s;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic          relu_en;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_sat;

    node_mac_seq #(.N_IN(N_IN), .DW(DW), .FRAC(FRAC)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .w_we      (w_we),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .relu_en   (relu_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int stall_req = 0;
    logic rand_ready = 1'b0;
    int out_hs_cyc = -100;

    exp_t exp_q[$];
    int   lat_q[$];

    logic [DW-1:0] mw [N_IN];
    logic [DW-1:0] mb;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic fail_note(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference: exact integer dot product, bias scaled by 2^FRAC, floor shift, clamp, ReLU.
    function automatic exp_t ref_model(input frame_t x, input logic relu);
        longint acc;
        longint r;
        exp_t   e;
        acc = longint'($signed(mb)) * (longint'(1) << FRAC);
        for (int i = 0; i < N_IN; i++) begin
            acc += longint'($signed(x[i])) * longint'($signed(mw[i]));
        end
        r = acc >>> FRAC;
        e.s = 1'b0;
        if (r > 32767) begin
            r = 32767;
            e.s = 1'b1;
        end else if (r < -32768) begin
            r = -32768;
            e.s = 1'b1;
        end
        if (relu && r < 0) r = 0;
        e.d = r[DW-1:0];
        return e;
    endfunction

    // Monitor: latency, hold-while-stalled, and scoreboard pop at each handshake.
    logic          prev_valid = 1'b0;
    logic          prev_hs    = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_sat   = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (prev_hs) check("valid_drop_after_hs", {31'd0, out_valid}, 32'd0);
            if (prev_valid && !prev_hs) begin
                check("valid_hold", {31'd0, out_valid}, 32'd1);
                check("data_hold", {16'd0, out_data}, {16'd0, prev_data});
                check("sat_hold", {31'd0, out_sat}, {31'd0, prev_sat});
            end
            if (out_valid) begin
                check("in_ready_low_pending", {31'd0, in_ready}, 32'd0);
                if (!prev_valid) begin
                    if (lat_q.size() == 0) fail_note("unexpected_out_valid");
                    else check("out_latency", cyc, lat_q.pop_front());
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_note("unexpected_output");
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", {16'd0, out_data}, {16'd0, e.d});
                        check("out_sat", {31'd0, out_sat}, {31'd0, e.s});
                    end
                    out_hs_cyc = cyc;
                end
            end
        end
        prev_valid = out_valid && reset;
        prev_hs    = out_valid && out_ready && reset;
        prev_data  = out_data;
        prev_sat   = out_sat;
    end

    // Downstream: optional stall of stall_req cycles at each new result, else ready/random.
    initial begin
        int   left = 0;
        logic seen = 1'b0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid && !seen) left = stall_req;
            seen = out_valid;
            if (out_valid && left > 0) begin
                out_ready = 1'b0;
                left--;
            end else begin
                out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    task automatic write_w(input int addr, input logic [DW-1:0] data);
        w_we   = 1'b1;
        w_addr = AW'(addr);
        w_data = data;
        @(posedge clk);
        #1;
        w_we = 1'b0;
        if (addr == N_IN) mb = data;
        else if (addr < N_IN) mw[addr] = data;
    endtask

    task automatic load_all(input logic [DW-1:0] w, input logic [DW-1:0] b);
        for (int i = 0; i < N_IN; i++) write_w(i, w);
        write_w(N_IN, b);
    endtask

    task automatic send_sample(input logic [DW-1:0] x, output int hs);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = x;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) fail_note("in_ready_timeout");
        hs = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom();
    endtask

    task automatic send_frame(input frame_t x, input logic relu, input int maxgap,
                              input logic directed, input logic [DW-1:0] ed, input logic es,
                              output int first_hs);
        int   hs;
        exp_t e;
        relu_en = relu;
        for (int i = 0; i < N_IN; i++) begin
            if (maxgap > 0) begin
                repeat ($urandom_range(0, maxgap)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_sample(x[i], hs);
            if (i == 0) first_hs = hs;
        end
        if (directed) begin
            e.d = ed;
            e.s = es;
        end else begin
            e = ref_model(x, relu);
        end
        exp_q.push_back(e);
        lat_q.push_back(hs + 2);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int g = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || out_valid) && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (exp_q.size() != 0 || out_valid) fail_note("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd_val();
        int v;
        if ($urandom_range(0, 3) == 0) return DW'($urandom());
        v = int'($urandom_range(0, 2047)) - 1024;
        return v[DW-1:0];
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog_timeout");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t fa, fb, f;
        int     fh;
        in_valid = 1'b0;
        in_data  = '0;
        w_we     = 1'b0;
        w_addr   = '0;
        w_data   = '0;
        relu_en  = 1'b0;
        mb       = '0;
        for (int i = 0; i < N_IN; i++) mw[i] = '0;
        fa = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};

        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        check("rst_out_sat", {31'd0, out_sat}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Basic 1.0 weights: 1+2+3+4 = 10.0
        load_all(16'h0100, 16'h0000);
        send_frame(fa, 1'b0, 0, 1'b1, 16'h0A00, 1'b0, fh);
        wait_done();

        // Negative bias, with and without ReLU
        write_w(N_IN, 16'hFA00);
        f = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
        send_frame(f, 1'b0, 0, 1'b1, 16'hFE00, 1'b0, fh);
        wait_done();
        send_frame(f, 1'b1, 0, 1'b1, 16'h0000, 1'b0, fh);
        wait_done();

        // Positive and negative saturation
        load_all(16'h7FFF, 16'h0000);
        f = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        send_frame(f, 1'b0, 0, 1'b1, 16'h7FFF, 1'b1, fh);
        wait_done();
        load_all(16'h8000, 16'h0000);
        send_frame(f, 1'b0, 0, 1'b1, 16'h8000, 1'b1, fh);
        wait_done();

        // Output stall with next frame already presented
        load_all(16'h0100, 16'h0000);
        stall_req = 5;
        send_frame(fa, 1'b0, 0, 1'b1, 16'h0A00, 1'b0, fh);
        fb = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
        send_frame(fb, 1'b0, 0, 1'b1, 16'h0400, 1'b0, fh);
        check("next_frame_start", fh, out_hs_cyc + 1);
        wait_done();
        stall_req = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-frame with a simultaneous weight write
        send_sample(16'h0100, fh);
        send_sample(16'h0200, fh);
        reset  = 1'b0;
        w_we   = 1'b1;
        w_addr = '0;
        w_data = 16'h1234;
        @(posedge clk);
        #1;
        reset = 1'b1;
        w_we  = 1'b0;
        mb = '0;
        for (int i = 0; i < N_IN; i++) mw[i] = '0;
        @(negedge clk);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        send_frame(fa, 1'b0, 0, 1'b1, 16'h0000, 1'b0, fh);
        wait_done();
        load_all(16'h0100, 16'h0000);
        send_frame(fa, 1'b0, 0, 1'b1, 16'h0A00, 1'b0, fh);
        wait_done();

        // Gapped input plus a bias write while the result is pending
        stall_req = 3;
        send_frame(fa, 1'b0, 4, 1'b1, 16'h0A00, 1'b0, fh);
        check("bias_write_in_out", {31'd0, out_valid}, 32'd1);
        write_w(N_IN, 16'h0100);
        wait_done();
        stall_req = 0;
        repeat (2) @(posedge clk);
        #1;
        send_frame(fb, 1'b0, 3, 1'b1, 16'h0500, 1'b0, fh);
        wait_done();

        // Randomized frames against the reference model
        rand_ready = 1'b1;
        for (int t = 0; t < 30; t++) begin
            repeat ($urandom_range(0, 3)) write_w(int'($urandom_range(0, 7)), rnd_val());
            for (int i = 0; i < N_IN; i++) f[i] = rnd_val();
            send_frame(f, 1'($urandom_range(0, 1)), 3, 1'b0, 16'h0000, 1'b0, fh);
        end
        wait_done();
        rand_ready = 1'b0;

        check("queue_drained", exp_q.size(), 32'd0);
        check("latency_queue_drained", lat_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
